// File: rtl/dbg_uart_tx_if.sv
// Bundle of the push-side and status signals of the debug UART transmitter.
// master: the digital core pushing bytes; slave: the transmitter itself.
interface dbg_uart_tx_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [7:0]    dbg_data;
   logic          dbg_tx;
   logic          TX;
   logic          dbg_done;
   logic          busy;
   logic          full;
   logic [CW-1:0] count;
   logic          ovfl;

   modport master (
      output dbg_data, dbg_tx,
      input  TX, dbg_done, busy, full, count, ovfl
   );

   modport slave (
      input  dbg_data, dbg_tx,
      output TX, dbg_done, busy, full, count, ovfl
   );
endinterface

// File: rtl/dbg_uart_tx.sv
// Buffered 8N1 UART transmitter for the debug/status link to the BLE112.
// Bytes are pushed into a small circular FIFO and serialized back-to-back,
// LSB first, one start bit (0) and one stop bit (1), BAUD_DIV clocks per bit.
module dbg_uart_tx #(
   parameter int unsigned BAUD_DIV = 434,
   parameter int unsigned DEPTH    = 4
) (
   input logic          clk,
   input logic          rst,
   dbg_uart_tx_if.slave bus
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   localparam logic [11:0]   BAUD_LAST = 12'(BAUD_DIV - 1);
   // dbg_done is registered, so it is set one cycle ahead of the stop bit's last cycle
   localparam logic [11:0]   DONE_AT   = 12'(BAUD_DIV - 2);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [3:0]    LAST_BIT  = 4'd9;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_XMIT = 1'b1;

   logic          state_q, state_d;
   logic [11:0]   baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   // Shifter bit 0 drives the line directly, so TX is a flop output.
   logic [9:0]    shift_q, shift_d;
   logic          done_q, done_d;
   logic          ovfl_q, ovfl_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    mem_q [DEPTH];

   logic full;
   logic baud_term;
   logic frame_end;
   logic pop;
   logic push;
   logic drop;

   // FIFO handshake decode; a pop frees a slot for a same-cycle push even when full
   always_comb begin
      full      = (count_q == DEPTH_C);
      baud_term = (baud_q == BAUD_LAST);
      frame_end = (state_q == ST_XMIT) && baud_term && (bit_q == LAST_BIT);
      pop       = (count_q != '0) && ((state_q == ST_IDLE) || frame_end);
      push      = bus.dbg_tx && (!full || pop);
      drop      = bus.dbg_tx && full && !pop;
   end

   // FIFO pointer, occupancy and overflow next-state
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ovfl_d = ovfl_q | drop;
   end

   // Frame sequencer: load, bit timing, shifting and back-to-back reload
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         ST_IDLE: begin
            shift_d = '1;
            if (pop) begin
               shift_d = {1'b1, mem_q[rptr_q], 1'b0};
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_XMIT;
            end
         end
         ST_XMIT: begin
            if (baud_term) begin
               baud_d = '0;
               if (bit_q == LAST_BIT) begin
                  bit_d = '0;
                  if (pop) begin
                     shift_d = {1'b1, mem_q[rptr_q], 1'b0};
                  end else begin
                     shift_d = {1'b1, shift_q[9:1]};
                     state_d = ST_IDLE;
                  end
               end else begin
                  shift_d = {1'b1, shift_q[9:1]};
                  bit_d   = bit_q + 4'd1;
               end
            end else begin
               baud_d = baud_q + 12'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            shift_d = '1;
         end
      endcase
      done_d = (state_q == ST_XMIT) && (bit_q == LAST_BIT) && (baud_q == DONE_AT);
   end

   // Control and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '1;
         done_q  <= 1'b0;
         ovfl_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         done_q  <= done_d;
         ovfl_q  <= ovfl_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wptr_q] <= bus.dbg_data;
      end
   end

   assign bus.TX       = shift_q[0];
   assign bus.dbg_done = done_q;
   assign bus.busy     = (state_q == ST_XMIT) || (count_q != '0);
   assign bus.full     = full;
   assign bus.count    = count_q;
   assign bus.ovfl     = ovfl_q;

endmodule

// File: tb/tb_dbg_uart_tx.sv
// Bench for dbg_uart_tx: directed scenarios plus random bursts, checked by a
// frame-level reference model and an independent serial-line decoder.
module tb_dbg_uart_tx;

   localparam int unsigned B  = 8;
   localparam int unsigned D  = 4;
   localparam int unsigned FB = 10 * B;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dbg_uart_tx_if #(.DEPTH(D)) bus ();

   dbg_uart_tx #(.BAUD_DIV(B), .DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] m_fifo [$];
   logic [7:0] sb_q [$];
   int         busy_left = 0;
   bit         m_ovfl = 1'b0;
   bit         rst_seen = 1'b1;

   // Line monitor state
   bit         chk_en = 1'b0;
   bit         in_frame = 1'b0;
   int         pos = 0;
   logic       samp [FB];
   int         max_count = 0;
   bit         saw_full = 1'b0;
   int         done_pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a byte starts a 10-bit frame when the line is free or the current
   // frame is in its final cycle; a push is kept if there is room after that pop.
   initial forever begin
      bit pop;
      bit room;
      @(posedge clk);
      rst_seen = rst;
      if (rst) begin
         m_fifo.delete();
         sb_q.delete();
         busy_left = 0;
         m_ovfl    = 1'b0;
      end else begin
         pop  = (m_fifo.size() != 0) && (busy_left <= 1);
         room = (m_fifo.size() < D) || pop;
         if (pop) begin
            sb_q.push_back(m_fifo.pop_front());
            busy_left = FB;
         end else if (busy_left > 0) begin
            busy_left--;
         end
         if (bus.dbg_tx) begin
            if (room) m_fifo.push_back(bus.dbg_data);
            else      m_ovfl = 1'b1;
         end
      end
   end

   task automatic finish_frame();
      bit         stable = 1'b1;
      logic [7:0] rx;
      for (int k = 0; k < 10; k++)
         for (int j = 0; j < int'(B); j++)
            if (samp[k*B + j] !== samp[k*B]) stable = 1'b0;
      check("bit_stable", stable, 1);
      check("stop_bit", samp[9*B + B/2], 1);
      for (int i = 0; i < 8; i++) rx[i] = samp[(i+1)*B + B/2];
      if (sb_q.size() == 0) begin
         check("unexpected_frame", 1, 0);
      end else begin
         check("tx_byte", rx, sb_q.pop_front());
      end
   endtask

   // Monitor: status outputs against the model, serial line decoded bit by bit
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("count", bus.count, m_fifo.size());
         check("full", bus.full, m_fifo.size() == D);
         check("busy", bus.busy, (busy_left > 0) || (m_fifo.size() != 0));
         check("ovfl", bus.ovfl, m_ovfl);
         if (int'(bus.count) > max_count) max_count = int'(bus.count);
         if (bus.full === 1'b1) saw_full = 1'b1;
         if (bus.dbg_done === 1'b1) done_pulses++;
         if (rst_seen) begin
            check("tx_in_reset", bus.TX, 1);
            check("done_in_reset", bus.dbg_done, 0);
            in_frame = 1'b0;
         end else begin
            if (!in_frame) begin
               if (bus.TX === 1'b0) begin
                  in_frame = 1'b1;
                  pos      = 0;
               end else begin
                  check("tx_idle", bus.TX, 1);
                  check("done_idle", bus.dbg_done, 0);
               end
            end
            if (in_frame) begin
               samp[pos] = bus.TX;
               check("done_pos", bus.dbg_done, pos == int'(FB) - 1);
               pos++;
               if (pos == int'(FB)) begin
                  in_frame = 1'b0;
                  finish_frame();
               end
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] d);
      @(negedge clk);
      bus.dbg_tx   = 1'b1;
      bus.dbg_data = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.dbg_tx = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((busy_left != 0 || m_fifo.size() != 0 || in_frame) && t < 3000) begin
         @(negedge clk);
         bus.dbg_tx = 1'b0;
         t++;
      end
      check("drain_in_time", t < 3000, 1);
      idle(2);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      bus.dbg_tx = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] burst [4];
      int         probs [4];
      int         t;
      burst = '{8'h00, 8'hFF, 8'h55, 8'h81};
      probs = '{2, 6, 20, 100};
      bus.dbg_tx   = 1'b0;
      bus.dbg_data = 8'h00;
      rst          = 1'b1;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Reset values
      check("rst_tx", bus.TX, 1);
      check("rst_done", bus.dbg_done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_full", bus.full, 0);
      check("rst_count", bus.count, 0);
      check("rst_ovfl", bus.ovfl, 0);

      // Single byte: start bit two edges after the push
      push_byte(8'hA5);
      @(negedge clk);
      bus.dbg_tx = 1'b0;
      check("a5_tx_after_write", bus.TX, 1);
      check("a5_count", bus.count, 1);
      @(negedge clk);
      check("a5_start_bit", bus.TX, 0);
      done_pulses = 0;
      drain();
      check("a5_done_pulses", done_pulses, 1);
      check("a5_busy_after", bus.busy, 0);

      // Burst of four consecutive pushes
      max_count   = 0;
      saw_full    = 1'b0;
      done_pulses = 0;
      for (int i = 0; i < 4; i++) push_byte(burst[i]);
      drain();
      check("burst_peak", max_count, 3);
      check("burst_full", saw_full, 0);
      check("burst_ovfl", bus.ovfl, 0);
      check("burst_done_pulses", done_pulses, 4);

      // Overflow: eight pushes while idle, 6..8 dropped
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      @(negedge clk);
      bus.dbg_tx = 1'b0;
      check("ovf_full", bus.full, 1);
      check("ovf_ovfl", bus.ovfl, 1);
      drain();
      check("ovf_sticky", bus.ovfl, 1);
      pulse_reset();
      check("ovf_cleared", bus.ovfl, 0);

      // Push on full in the cycle the stop bit ends
      push_byte(8'h11);
      for (int i = 0; i < 4; i++) push_byte(8'h21 + 8'(i));
      @(negedge clk);
      bus.dbg_tx = 1'b0;
      check("pf_fill_count", bus.count, 4);
      t = 0;
      while (bus.dbg_done !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("pf_done_seen", t < 200, 1);
      bus.dbg_tx   = 1'b1;
      bus.dbg_data = 8'h99;
      @(negedge clk);
      bus.dbg_tx = 1'b0;
      check("pf_count", bus.count, 4);
      check("pf_ovfl", bus.ovfl, 0);
      check("pf_full", bus.full, 1);
      drain();

      // Reset during D3 with two bytes queued
      push_byte(8'h5A);
      push_byte(8'h6B);
      push_byte(8'h7C);
      @(negedge clk);
      bus.dbg_tx = 1'b0;
      idle(4 * B + 1);
      check("mid_queued", bus.count, 2);
      check("mid_d3_bit", bus.TX, 1);
      done_pulses = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_tx_high", bus.TX, 1);
      check("mid_count", bus.count, 0);
      check("mid_busy", bus.busy, 0);
      check("mid_done", bus.dbg_done, 0);
      idle(2 * FB);
      check("mid_no_done", done_pulses, 0);
      push_byte(8'h3C);
      drain();

      // Random traffic at several push densities with rare resets
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.dbg_tx   = ($urandom_range(0, probs[s] - 1) == 0);
            bus.dbg_data = 8'($urandom);
            rst          = ($urandom_range(0, 499) == 0);
         end
         @(negedge clk);
         rst        = 1'b0;
         bus.dbg_tx = 1'b0;
         drain();
      end

      check("scoreboard_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule

// File: doc/dbg_uart_tx.md
# dbg_uart_tx

Buffered 8N1 UART transmitter for the follower's debug/status link back to the BLE112 module. It is the transmit counterpart of the command receiver: it drives the module's RX pin. The digital core pushes `dbg_data` bytes with a `dbg_tx` strobe into a small FIFO. The block serializes them back-to-back at a fixed baud rate and pulses `dbg_done` as each frame completes.

## Interface
Parameters:
- BAUD_DIV, 434 — clk cycles per bit (50 MHz / 115200); legal range 4..4095.
- DEPTH, 4 — FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- dbg_data  in  8  byte to send, sampled when dbg_tx=1.
- dbg_tx  in  1  push strobe, one byte per cycle high.
- TX  out  1  serial line, idle high.
- dbg_done  out  1  one-cycle pulse at end of each stop bit.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovfl  out  1  sticky: a push was dropped; cleared only by rst.

## Operation
- **FIFO:** circular buffer with a write pointer, a read pointer and an occupancy counter. Pointers wrap modulo DEPTH.
- **Push:** `dbg_tx=1` and (`!full` or pop in the same cycle) → write `dbg_data`, increment wptr.
- **Dropped push:** `dbg_tx=1` while full with no pop → byte dropped, `ovfl` set, FIFO unchanged.
- **Simultaneous push+pop:** both take effect and `count` is unchanged. This includes the full case, where the popped slot frees room.
- **State machine**, states IDLE and XMIT:
  - **IDLE:** TX=1. If count≠0, load shifter `{1'b1, fifo[rptr], 1'b0}` (10 bits), pop, clear baud and bit counters, go to XMIT.
  - **XMIT:** TX = shifter[0]. The baud counter counts 0..BAUD_DIV-1. At terminal count the shifter shifts right (fill 1) and the bit counter increments.
  - **Exit from XMIT:** when bit counter=9 reaches terminal count, pulse `dbg_done`. If count≠0, reload the next byte and stay in XMIT; no idle gap. Otherwise go to IDLE.
- **Frame format:** start(0), D0..D7 LSB first, stop(1).
- **busy** = (state==XMIT) | (count≠0).
- **Reset mid-frame:** frame is aborted and TX returns high on the next cycle. FIFO is emptied and pending bytes are lost.

## Timing
- **Reset values:** TX=1, dbg_done=0, busy=0, full=0, count=0, ovfl=0, state IDLE, pointers 0.
- **Latency:** `dbg_tx` sampled at edge N, with FIFO empty and IDLE → byte written at N; start bit appears on TX after edge N+1.
- **Bit time:** each bit lasts exactly BAUD_DIV cycles; a frame is 10·BAUD_DIV cycles.
- **dbg_done timing:** `dbg_done` is high in the last cycle of the stop bit, once per frame.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the stop bit's last cycle.
- **count/full:** update on the edge after a push or pop; `full` = (count==DEPTH).
- **Registered outputs:** TX, `dbg_done` and `ovfl` are registers, so TX has no glitches.

## Test plan
- **Single byte** (BAUD_DIV=8): push 0xA5 after reset → TX goes low 2 edges later, then bits 1,0,1,0,0,1,0,1 and stop 1, each 8 cycles. `dbg_done` pulses once at cycle 80 of the frame; `busy` then drops.
- **Burst of 4** (DEPTH=4): push 0x00,0xFF,0x55,0x81 in 4 consecutive cycles.
  - Four frames back-to-back with no idle cycles, and 4 `dbg_done` pulses 80 cycles apart.
  - `count` peaks at 3 (first byte popped on the cycle after its write), `full` never set, `ovfl`=0.
- **Overflow:** hold `dbg_tx` for 8 cycles with data 1..8 while idle.
  - Transmitted bytes are 1..5: 1 is in the shifter, 2..5 fill the FIFO, and 6..8 are dropped.
  - `full`=1 and `ovfl`=1, sticky until rst.
- **Push on full with pop:** fill FIFO while frame 0x11 is in flight; push 0x99 in the exact cycle the stop bit ends and the next byte is popped → 0x99 accepted, `ovfl` stays 0, `count` stays 4.
- **Reset mid-frame:** assert rst during bit D3 with 2 bytes queued → TX=1 next cycle, count=0, `busy`=0, no `dbg_done`. A following push of 0x3C transmits correctly.
